// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI UART receiver and Note On/Off/All-Notes-Off parser
// Emits one-cycle 16-bit command words for the bank manager; 16'h0000 otherwise.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } uart_state_t;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_OFF,
    RS_ON,
    RS_CC
  } run_status_t;

  logic          rx_m;
  logic          rx_s;
  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_rdy;
  run_status_t   run_status;
  logic [1:0]    need;
  logic [6:0]    d1;
  logic [6:0]    d2;
  logic          note_ok;
  logic [15:0]   cmd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // Reset lands in WAIT_HIGH so a frame already on the wire is never decoded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_WAIT_HIGH;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_rdy    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      byte_rdy    <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              byte_rdy <= 1'b1;
              state    <= S_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_WAIT_HIGH;
      endcase
    end
  end

  // shift holds the completed byte while byte_rdy is high.
  assign d2      = shift[6:0];
  assign note_ok = (d1 != 7'd0) && (d1 != 7'h7F);

  always_comb begin
    cmd = 16'h0000;
    case (run_status)
      RS_ON:  if (note_ok) cmd = {(d2 != 7'd0), d1, 1'b0, d2};
      RS_OFF: if (note_ok) cmd = {1'b0, d1, 1'b0, d2};
      RS_CC:  if (d1 == 7'd120 || d1 == 7'd123) cmd = 16'h7F00;
      default: cmd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_status <= RS_NONE;
      need       <= 2'd2;
      d1         <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_data  <= '0;
      o_valid <= 1'b0;
      if (o_frame_err) begin
        run_status <= RS_NONE;
        need       <= 2'd2;
      end else if (byte_rdy) begin
        if (shift[7]) begin
          // 0xF8-0xFF are real-time bytes and leave parser state alone.
          if (shift[7:3] != 5'b11111) begin
            need <= 2'd2;
            case (shift[7:4])
              4'h8:    run_status <= RS_OFF;
              4'h9:    run_status <= RS_ON;
              4'hB:    run_status <= RS_CC;
              default: run_status <= RS_NONE;
            endcase
          end
        end else if (run_status != RS_NONE) begin
          if (need == 2'd2) begin
            d1   <= shift[6:0];
            need <= 2'd1;
          end else begin
            need    <= 2'd2;
            o_data  <= cmd;
            o_valid <= (cmd != 16'h0000);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - self-checking bench for midi_uart_rx
// Bytes are serialized on i_rx; a message-level model predicts commands and frame errors.
module tb_midi_uart_rx;

  localparam int CPB = 16;
  localparam int LAT_CMD = 156;
  localparam int LAT_FERR = 155;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_rx = 1'b1;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_frame_err;

  midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [15:0] data;
    int          t0;
  } exp_t;
  exp_t exp_q[$];
  int   ferr_q[$];
  exp_t e;
  int   ft;

  // Message-level model: status nibble (-1 = none), data bytes still needed, first data byte.
  int m_rs = -1;
  int m_need = 2;
  int m_d1 = 0;

  function automatic logic [15:0] model_byte(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 248) return 16'h0000;
    if (v >= 128) begin
      m_rs = ((v / 16 == 8) || (v / 16 == 9) || (v / 16 == 11)) ? v / 16 : -1;
      m_need = 2;
      return 16'h0000;
    end
    if (m_rs < 0) return 16'h0000;
    if (m_need == 2) begin
      m_d1 = v;
      m_need = 1;
      return 16'h0000;
    end
    m_need = 2;
    if (m_rs == 11) return (m_d1 == 120 || m_d1 == 123) ? 16'h7F00 : 16'h0000;
    if (m_d1 == 0 || m_d1 == 127) return 16'h0000;
    if (m_rs == 9 && v != 0) return 16'(32768 + m_d1 * 256 + v);
    return 16'(m_d1 * 256 + v);
  endfunction

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called #1 after a posedge; returns that way too.
  task automatic send(input logic [7:0] b, input bit good, input int gap, output logic [15:0] mcmd);
    int t0;
    t0 = cyc;
    if (good) begin
      mcmd = model_byte(b);
      if (mcmd != 16'h0000) exp_q.push_back('{mcmd, t0});
    end else begin
      mcmd = 16'h0000;
      m_rs = -1;
      m_need = 2;
      ferr_q.push_back(t0);
    end
    i_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_cycles(CPB);
    end
    i_rx = good;
    wait_cycles(CPB);
    i_rx = 1'b1;
    wait_cycles(gap * CPB);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (o_valid !== (o_data != 16'h0000)) begin
        miscompares++;
        $display("FAIL valid_vs_data: o_valid %b with o_data %h at cycle %0d", o_valid, o_data, cyc);
      end
      if (o_data != 16'h0000) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_cmd: got %h expected 0000 at cycle %0d", o_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.data || cyc - e.t0 < LAT_CMD - 1 || cyc - e.t0 > LAT_CMD + 1) begin
            miscompares++;
            $display("FAIL cmd: got %h after %0d cycles, expected %h after %0d+-1",
                     o_data, cyc - e.t0, e.data, LAT_CMD);
          end
        end
      end
      if (exp_q.size() > 0 && cyc - exp_q[0].t0 > LAT_CMD + 1) begin
        vectors++;
        miscompares++;
        e = exp_q.pop_front();
        $display("FAIL missing_cmd: got nothing expected %h by cycle %0d", e.data, e.t0 + LAT_CMD + 1);
      end
      if (o_frame_err) begin
        vectors++;
        if (ferr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame_err: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          ft = ferr_q.pop_front();
          if (cyc - ft < LAT_FERR - 1 || cyc - ft > LAT_FERR + 1) begin
            miscompares++;
            $display("FAIL frame_err_time: got %0d cycles expected %0d+-1", cyc - ft, LAT_FERR);
          end
        end
      end
      if (ferr_q.size() > 0 && cyc - ferr_q[0] > LAT_FERR + 1) begin
        vectors++;
        miscompares++;
        ft = ferr_q.pop_front();
        $display("FAIL missing_frame_err: got 0 expected 1 by cycle %0d", ft + LAT_FERR + 1);
      end
    end
  end

  function automatic logic [7:0] rand_byte();
    int r;
    int s;
    logic [7:0] v;
    r = $urandom_range(0, 99);
    if (r < 6) return 8'h90 | 8'($urandom_range(0, 15));
    if (r < 10) return 8'h80 | 8'($urandom_range(0, 15));
    if (r < 14) return 8'hB0 | 8'($urandom_range(0, 15));
    if (r < 18) begin
      v = 8'($urandom_range(160, 247));
      if (v[7:4] == 4'hB) v = 8'hE0;
      return v;
    end
    if (r < 22) return 8'($urandom_range(248, 255));
    s = $urandom_range(0, 19);
    if (s == 0) return 8'h00;
    if (s == 1) return 8'h7F;
    if (s == 2) return 8'd120;
    if (s == 3) return 8'd123;
    return 8'($urandom_range(0, 127));
  endfunction

  logic [15:0] mc;
  logic [7:0]  rb;
  bit          rg;

  initial begin
    reset_n = 1'b0;
    i_rx = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(3);
    chk("reset_o_data", o_data, 16'h0000);
    chk("reset_o_valid", 16'(o_valid), 16'h0000);
    chk("reset_o_frame_err", 16'(o_frame_err), 16'h0000);
    reset_n = 1'b1;
    checking = 1'b1;
    wait_cycles(2 * CPB);

    send(8'h90, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h64, 1, 2, mc);
    chk("model_note_on", mc, 16'hBC64);

    send(8'h91, 1, 0, mc);
    send(8'h40, 1, 0, mc);
    send(8'h7F, 1, 0, mc);
    chk("model_running_on", mc, 16'hC07F);
    send(8'h40, 1, 0, mc);
    send(8'h00, 1, 2, mc);
    chk("model_vel0_off", mc, 16'h4000);

    send(8'h80, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'hF8, 1, 0, mc);
    chk("model_realtime", mc, 16'h0000);
    send(8'h40, 1, 2, mc);
    chk("model_note_off", mc, 16'h3C40);

    send(8'hB0, 1, 0, mc);
    send(8'h7B, 1, 0, mc);
    send(8'h00, 1, 1, mc);
    chk("model_all_off", mc, 16'h7F00);
    send(8'h90, 1, 0, mc);
    send(8'h7F, 1, 0, mc);
    send(8'h10, 1, 1, mc);
    chk("model_note127", mc, 16'h0000);
    send(8'h90, 1, 0, mc);
    send(8'h00, 1, 0, mc);
    send(8'h10, 1, 1, mc);
    chk("model_note0", mc, 16'h0000);
    send(8'hA0, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h10, 1, 2, mc);
    chk("model_aftertouch", mc, 16'h0000);

    send(8'h90, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h55, 0, 2, mc);
    send(8'h64, 1, 1, mc);
    chk("model_after_ferr", mc, 16'h0000);
    send(8'h90, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h64, 1, 4, mc);
    chk("model_recover", mc, 16'hBC64);

    wait_cycles(12 * CPB);
    fork
      send(8'h3C, 1, 20, mc);
      begin
        wait_cycles(85);
        reset_n = 1'b0;
        wait_cycles(1);
        chk("midreset_o_data", o_data, 16'h0000);
        chk("midreset_o_valid", 16'(o_valid), 16'h0000);
        chk("midreset_o_frame_err", 16'(o_frame_err), 16'h0000);
        wait_cycles(1);
        reset_n = 1'b1;
        m_rs = -1;
        m_need = 2;
      end
    join
    send(8'h90, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h64, 1, 2, mc);
    chk("model_after_reset", mc, 16'hBC64);

    i_rx = 1'b0;
    wait_cycles(3);
    i_rx = 1'b1;
    wait_cycles(3 * CPB);
    send(8'h92, 1, 0, mc);
    send(8'h3C, 1, 0, mc);
    send(8'h64, 1, 2, mc);
    chk("model_after_glitch", mc, 16'hBC64);

    for (int n = 0; n < 250; n++) begin
      rb = rand_byte();
      rg = ($urandom_range(0, 19) != 0);
      send(rb, rg, rg ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)), mc);
    end

    wait_cycles(15 * CPB);
    vectors++;
    if (exp_q.size() != 0 || ferr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d cmds and %0d frame errors pending, expected 0",
               exp_q.size(), ferr_q.size());
    end
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial MIDI front end for the synthesizer voice path. Receives a 31250-baud MIDI stream and decodes Note On, Note Off and All-Notes-Off messages, including running status. Emits one-cycle 16-bit command words in the format the pipelined bank manager consumes on its `i_data` input. Sits between the board MIDI-in pin (after the opto-isolator) and the bank manager.

## Interface
- `CLKS_PER_BIT`, 1600: system clocks per UART bit (50 MHz / 31250); must be even and ≥ 8.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. Synchronous, active-low.
- `i_rx`  in  1  asynchronous serial line, idle high.
- `o_data`  out  16  command word.
  - [15] = 1 for note on, 0 for note off.
  - [14:8] = note number.
  - [7] = 0.
  - [6:0] = velocity.
  - 16'h0000 when idle.
- `o_valid`  out  1  one-cycle strobe, high exactly when `o_data` ≠ 0.
- `o_frame_err`  out  1  one-cycle strobe on a bad stop bit.

## Operation
- **Synchronizer:** `i_rx` passes through a 2-FF synchronizer. All logic uses the synchronized `rx_s`.
- **UART FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `rx_s` = 0, clear bit counter and go to START.
  - START: at CLKS_PER_BIT/2 cycles, sample `rx_s`.
    - 0: go to DATA.
    - 1 (glitch): go to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. Go to STOP after bit 7.
  - STOP: sample after CLKS_PER_BIT cycles.
    - 1: pulse internal `byte_rdy` for 1 cycle, go to IDLE.
    - 0: pulse `o_frame_err`, go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE when `rx_s` = 1.
- **Parser** (driven by `byte_rdy`). Holds `run_status` (the high nibble, or NONE) and `need` (0, 1 or 2 data bytes outstanding).
  - 0xF8–0xFF (real-time): ignored; no state change.
  - 0x80, 0x90, 0xB0 (any channel): set `run_status`, `need` = 2.
  - Any other status byte 0xA0–0xF7: `run_status` = NONE; following data bytes are ignored.
  - Data byte with `need` = 2: latch as d1, `need` = 1.
  - Data byte with `need` = 1: latch as d2, decode, `need` = 2 (running status).
  - Data byte with `run_status` = NONE: ignored.
- **Decode:**
  - Note On with d2 ≠ 0: `{1'b1, d1, 1'b0, d2}`.
  - Note On with d2 = 0, or Note Off: `{1'b0, d1, 1'b0, d2}`.
  - Control Change with d1 = 120 or 123: 16'h7F00 (STOP_ALL), regardless of d2.
  - Other Control Change numbers: no output.
  - Note numbers 0 and 127: dropped. 0 means "empty" downstream; note-off of 127 would alias STOP_ALL.
- **Frame error:** discards the partial message: `run_status` = NONE, `need` = 2.
- **Output hold:** `o_data` is 16'h0000 on every cycle without a command. This is required: downstream samples `i_data` every clock.

## Timing
- **Reset:** all state is cleared on any clock edge with `reset_n` = 0, including mid-frame.
  - `o_data` = 0, `o_valid` = 0, `o_frame_err` = 0.
  - FSM = WAIT_HIGH, so a byte already in progress on the line is never decoded.
  - `run_status` = NONE.
- **Sampling:** relative to the synchronized falling edge of the start bit, data bit k is sampled at (k + 1.5)·CLKS_PER_BIT and the stop bit at 9.5·CLKS_PER_BIT.
- **Latency:**
  - `byte_rdy` is asserted 1 cycle after the stop sample.
  - `o_data`/`o_valid` are registered 1 cycle after `byte_rdy`.
  - Total from the raw `i_rx` start edge is 9.5·CLKS_PER_BIT + 4 cycles, ±1 for synchronizer phase.
- **Throughput:** at most one command per byte time, so no backpressure is needed. The downstream `clk_en` is not used here.
- **Back-to-back frames:** a start bit arriving on the cycle after a good stop sample is detected; there is no dead time.

## Test plan
Sim uses CLKS_PER_BIT = 16.

- **Note On:** send 0x90, 0x3C, 0x64 -> exactly one cycle with `o_data` = 16'hBC64 and `o_valid` = 1; 16'h0000 otherwise.
- **Running status + zero-velocity off:** send 0x91, 0x40, 0x7F, 0x40, 0x00 -> 16'hC07F, then 16'h4000.
- **Note Off with real-time byte inside:** send 0x80, 0x3C, 0xF8, 0x40 -> single 16'h3C40; 0xF8 produces nothing.
- **All Notes Off and dropped notes:**
  - 0xB0, 0x7B, 0x00 -> 16'h7F00.
  - 0x90, 0x7F, 0x10 -> no output.
  - 0x90, 0x00, 0x10 -> no output.
  - 0xA0, 0x3C, 0x10 -> no output.
- **Frame error:** send 0x90, 0x3C, then a frame with stop bit = 0 -> `o_frame_err` pulses for 1 cycle. A following 0x64 gives no output; then 0x90, 0x3C, 0x64 -> 16'hBC64.
- **Reset during frame:** assert `reset_n` = 0 for 2 cycles during bit 4 of 0x3C, with `i_rx` still toggling -> outputs 0 and nothing decoded. After the line idles high, 0x90, 0x3C, 0x64 -> 16'hBC64.
- **Start-bit glitch:** 3-cycle low pulse on `i_rx` -> no byte, no `o_frame_err`.
